// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state codes and width helper for the stopwatch control slice.
// Optional lap/freeze feature is enabled by defining LAP_EN.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Width of a counter that must hold values 0..n-1 (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs between board, sequencer and datapath.
// LAP_EN adds the lap button and the display freeze flag.
interface stopwatch_ctrl_if;
    import stopwatch_ctrl_pkg::*;

    logic   btnL;
    logic   cnt_en;
    logic   cnt_clr;
    logic   scan_tick;
    logic   running;
    state_t state;
`ifdef LAP_EN
    logic   btnC;
    logic   freeze;
`endif

    modport master (
`ifdef LAP_EN
        input  btnC,
        output freeze,
`endif
        input  btnL,
        output cnt_en,
        output cnt_clr,
        output scan_tick,
        output running,
        output state
    );

    modport slave (
`ifdef LAP_EN
        output btnC,
        input  freeze,
`endif
        output btnL,
        input  cnt_en,
        input  cnt_clr,
        input  scan_tick,
        input  running,
        input  state
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Two-flop synchroniser, stable-count debouncer and edge pulses for one button.
// Used for btnL always and for btnC when LAP_EN is defined.
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise,
    output logic fall
);

    localparam int DW = cnt_width(DB_CYC);
    localparam logic [DW-1:0] DB_MAX = DW'(DB_CYC - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic          level_d;
    logic [DW-1:0] cnt;

    // bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // flip the level only after DB_CYC consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == DB_MAX) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // delayed level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_d <= 1'b0;
        else     level_d <= level;
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced pause/run button, IDLE/RUN/PAUSE/HOLD FSM,
// count/clear/scan pulses. Define LAP_EN for the lap button and freeze output.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 10,
    parameter int SCAN_HZ  = 1000,
    parameter int DB_CYC   = 1_000_000,
    parameter int HOLD_CYC = 100_000_000
) (
    input  logic clk,
    input  logic btnR,
    stopwatch_ctrl_if.master bus
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW = cnt_width(TICK_DIV);
    localparam int SW = cnt_width(SCAN_DIV);
    localparam int HW = cnt_width(HOLD_CYC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC - 1);

    logic          press;
    logic          rel;
    state_t        state_q;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold;
    logic [SW-1:0] scan_cnt;
    logic          cnt_en_q;
    logic          cnt_clr_q;
    logic          scan_q;
    logic          running_q;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_l (
        .clk  (clk),
        .rst  (btnR),
        .raw  (bus.btnL),
        .rise (press),
        .fall (rel)
    );

    // free-running digit-scan divider, independent of the FSM
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            scan_cnt <= '0;
            scan_q   <= 1'b0;
        end else begin
            scan_q   <= (scan_cnt == SCAN_MAX);
            scan_cnt <= (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + 1'b1;
        end
    end

    // FSM with prescaler, hold timer and registered pulse outputs
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            state_q   <= ST_IDLE;
            presc     <= '0;
            hold      <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    presc <= '0;
                    if (press) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // terminal count still fires on the pausing edge
                    cnt_en_q <= (presc == PRESC_MAX);
                    presc    <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
                    if (press) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (press) begin
                        state_q <= ST_HOLD;
                        hold    <= '0;
                    end
                end
                ST_HOLD: begin
                    if (rel) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (hold == HOLD_MAX) begin
                        state_q   <= ST_IDLE;
                        cnt_clr_q <= 1'b1;
                        presc     <= '0;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LAP_EN
    logic lap_rise;
    logic lap_fall;
    logic freeze_q;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_c (
        .clk  (clk),
        .rst  (btnR),
        .raw  (bus.btnC),
        .rise (lap_rise),
        .fall (lap_fall)
    );

    // lap toggles freeze while running; any exit from RUN clears it
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR)
            freeze_q <= 1'b0;
        else if (state_q == ST_RUN && !press)
            freeze_q <= freeze_q ^ lap_rise;
        else
            freeze_q <= 1'b0;
    end

    assign bus.freeze = freeze_q;
`endif

    assign bus.cnt_en    = cnt_en_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.scan_tick = scan_q;
    assign bus.running   = running_q;
    assign bus.state     = state_q;

endmodule
